// File: rtl/x1_sram_arbiter.sv
`default_nettype none
// ============================================================================
// x1_sram_arbiter : shares one byte-wide SRAM between the Z80 bus and the
//                   three-plane GRAM video fetch (B/R/G burst per request).
// Optional macro  : SRAM_ARB_GBANK_EN adds the GRAM bank-select inputs.
// Revision        : 1.0
// ============================================================================
module x1_sram_arbiter #(
  parameter int unsigned ACC_CYC = 3,
  parameter logic [7:0]  CPU_FD  = 8'hFF
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
`ifdef SRAM_ARB_GBANK_EN
  input  logic        I_GRP,
  input  logic        I_GWP,
  input  logic        I_GVP,
`endif
  input  logic        I_CRD,
  input  logic        I_CWR,
  input  logic [15:0] I_CA,
  input  logic [7:0]  I_CD,
  output logic [7:0]  O_CD,
  output logic        O_CWAIT_N,
  input  logic        I_IPL_CS,
  input  logic        I_RAM_CS,
  input  logic        I_GB_CS,
  input  logic        I_GR_CS,
  input  logic        I_GG_CS,
  input  logic        I_VREQ,
  input  logic [13:0] I_GA,
  output logic [7:0]  O_GB_D,
  output logic [7:0]  O_GR_D,
  output logic [7:0]  O_GG_D,
  output logic        O_VACK,
  output logic        O_VOVR,
  output logic [17:0] O_SRAM_A,
  output logic [7:0]  O_SRAM_D,
  input  logic [7:0]  I_SRAM_D,
  output logic        O_SRAM_OE,
  output logic        O_SRAM_WE,
  output logic        O_SRAM_WC
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_VID_B = 3'd1;
  localparam logic [2:0] ST_VID_R = 3'd2;
  localparam logic [2:0] ST_VID_G = 3'd3;
  localparam logic [2:0] ST_CPU   = 3'd4;

  localparam logic [3:0] K_LAST   = 4'(ACC_CYC - 1);
  localparam logic [3:0] K_WE_END = 4'(ACC_CYC - 2);

  logic [2:0]  state_q, state_d, dec_st, cur_st;
  logic [3:0]  cnt_q, cnt_d, cur_k;
  logic        vpend_q, served_q, last_vid_q;
  logic [13:0] ga_q;
  logic [7:0]  b_tmp_q, r_tmp_q, gb_q, gr_q, gg_q, cd_q;
  logic        vack_q, vovr_q;
  logic        any_cs, cpu_pend, cpu_req, cpu_cand, cpu_wr, cpu_done;
  logic        slot_end, vid_busy, vid_start, cpu_start;
  logic        vbank, cbank;
  logic [17:0] cpu_addr;

`ifdef SRAM_ARB_GBANK_EN
  logic gvp_q;
  assign vbank = gvp_q;
  assign cbank = I_CRD ? I_GRP : I_GWP;
`else
  assign vbank = 1'b0;
  assign cbank = 1'b0;
`endif

  assign any_cs   = I_IPL_CS | I_RAM_CS | I_GB_CS | I_GR_CS | I_GG_CS;
  assign cpu_pend = (I_CRD | I_CWR) & ~served_q & ~I_RESET;
  assign cpu_req  = cpu_pend & any_cs;
  // The request being completed by the current CPU slot must not re-win the next slot.
  assign cpu_cand = cpu_req & (state_q != ST_CPU);
  assign cpu_wr   = I_CWR & ~I_CRD;
  assign slot_end = (state_q != ST_IDLE) && (cnt_q == K_LAST);
  assign vid_busy = (state_q == ST_VID_B) || (state_q == ST_VID_R) || (state_q == ST_VID_G);
  assign cpu_done = ((state_q == ST_CPU) && slot_end) || (cpu_pend && !any_cs);
  assign vid_start = (state_d == ST_VID_B) && (state_q != ST_VID_B);
  assign cpu_start = (state_d == ST_CPU) && (state_q != ST_CPU);

  always_comb begin
    cpu_addr = 18'h0;
    if (I_IPL_CS)     cpu_addr = {2'b01, 1'b0, I_CA[14:0]};
    else if (I_RAM_CS) cpu_addr = {2'b00, I_CA};
    else if (I_GB_CS)  cpu_addr = {1'b1, cbank, 2'b00, I_CA[13:0]};
    else if (I_GR_CS)  cpu_addr = {1'b1, cbank, 2'b01, I_CA[13:0]};
    else if (I_GG_CS)  cpu_addr = {1'b1, cbank, 2'b10, I_CA[13:0]};
  end

  always_comb begin
    dec_st = ST_IDLE;
    if (I_RESET)                  dec_st = ST_IDLE;
    else if (vpend_q && cpu_cand) dec_st = last_vid_q ? ST_CPU : ST_VID_B;
    else if (vpend_q)             dec_st = ST_VID_B;
    else if (cpu_cand)            dec_st = ST_CPU;
  end

  // FSM: state register
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. From IDLE the granted slot starts in the same cycle (k=0 now).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (dec_st != ST_IDLE) begin
        state_d = dec_st;
        cnt_d   = 4'd1;
      end
    end else if (!slot_end) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd0;
      case (state_q)
        ST_VID_B: state_d = ST_VID_R;
        ST_VID_R: state_d = ST_VID_G;
        default:  state_d = dec_st;
      endcase
    end
  end

  assign cur_st = (state_q == ST_IDLE) ? dec_st : state_q;
  assign cur_k  = (state_q == ST_IDLE) ? 4'd0 : cnt_q;

  // FSM: outputs
  always_comb begin
    O_SRAM_A  = 18'h0;
    O_SRAM_D  = 8'h0;
    O_SRAM_OE = 1'b0;
    O_SRAM_WE = 1'b0;
    O_SRAM_WC = 1'b0;
    case (cur_st)
      ST_VID_B: begin O_SRAM_A = {1'b1, vbank, 2'b00, ga_q}; O_SRAM_OE = 1'b1; end
      ST_VID_R: begin O_SRAM_A = {1'b1, vbank, 2'b01, ga_q}; O_SRAM_OE = 1'b1; end
      ST_VID_G: begin O_SRAM_A = {1'b1, vbank, 2'b10, ga_q}; O_SRAM_OE = 1'b1; end
      ST_CPU: begin
        O_SRAM_A = cpu_addr;
        if (cpu_wr) begin
          O_SRAM_WC = 1'b1;
          O_SRAM_D  = I_CD;
          O_SRAM_WE = (cur_k >= 4'd1) && (cur_k <= K_WE_END);
        end else begin
          O_SRAM_OE = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      vpend_q    <= 1'b0;
      ga_q       <= 14'h0;
      served_q   <= 1'b0;
      last_vid_q <= 1'b0;
      b_tmp_q    <= 8'h0;
      r_tmp_q    <= 8'h0;
      gb_q       <= 8'h0;
      gr_q       <= 8'h0;
      gg_q       <= 8'h0;
      vack_q     <= 1'b0;
      vovr_q     <= 1'b0;
      cd_q       <= CPU_FD;
`ifdef SRAM_ARB_GBANK_EN
      gvp_q      <= 1'b0;
`endif
    end else begin
      vack_q <= 1'b0;
      vovr_q <= 1'b0;
      if (I_VREQ) begin
        if (vpend_q || vid_busy) begin
          vovr_q <= 1'b1;
        end else begin
          vpend_q <= 1'b1;
          ga_q    <= I_GA;
`ifdef SRAM_ARB_GBANK_EN
          gvp_q   <= I_GVP;
`endif
        end
      end
      if (vid_start) begin
        vpend_q    <= 1'b0;
        last_vid_q <= 1'b1;
      end
      if (cpu_start) last_vid_q <= 1'b0;

      if (!I_CRD && !I_CWR) served_q <= 1'b0;
      else if (cpu_done)    served_q <= 1'b1;

      if ((state_q == ST_CPU) && slot_end && I_CRD) cd_q <= I_SRAM_D;
      else if (cpu_pend && !any_cs && I_CRD)       cd_q <= CPU_FD;

      // B and R are staged so all three planes present together after G.
      if (slot_end) begin
        case (state_q)
          ST_VID_B: b_tmp_q <= I_SRAM_D;
          ST_VID_R: r_tmp_q <= I_SRAM_D;
          ST_VID_G: begin
            gb_q   <= b_tmp_q;
            gr_q   <= r_tmp_q;
            gg_q   <= I_SRAM_D;
            vack_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign O_CD      = cd_q;
  assign O_CWAIT_N = ~cpu_pend;
  assign O_GB_D    = gb_q;
  assign O_GR_D    = gr_q;
  assign O_GG_D    = gg_q;
  assign O_VACK    = vack_q;
  assign O_VOVR    = vovr_q;

endmodule
`default_nettype wire

// File: tb/tb_x1_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_x1_sram_arbiter : directed self-checking bench with a behavioural SRAM.
// Revision           : 1.0
// ============================================================================
module tb_x1_sram_arbiter;

  logic        I_CLK = 1'b0;
  logic        I_RESET, I_CRD, I_CWR, I_VREQ;
  logic        I_IPL_CS, I_RAM_CS, I_GB_CS, I_GR_CS, I_GG_CS;
  logic [15:0] I_CA;
  logic [7:0]  I_CD, O_CD, O_GB_D, O_GR_D, O_GG_D, O_SRAM_D, I_SRAM_D;
  logic [13:0] I_GA;
  logic        O_CWAIT_N, O_VACK, O_VOVR, O_SRAM_OE, O_SRAM_WE, O_SRAM_WC;
  logic [17:0] O_SRAM_A;
`ifdef SRAM_ARB_GBANK_EN
  logic        I_GRP, I_GWP, I_GVP;
`endif

  logic [7:0]  mem [0:262143];
  logic [17:0] addr_log [0:63];
  logic        we_log [0:63];
  logic        wc_log [0:63];
  int          log_n = 0;
  int          cyc = 0, vack_n = 0, vovr_n = 0, vack_cyc = 0, vreq_cyc = 0;
  int          total = 0, bad = 0;

  assign I_SRAM_D = mem[O_SRAM_A];

  always #5 I_CLK = ~I_CLK;

  x1_sram_arbiter dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET),
`ifdef SRAM_ARB_GBANK_EN
    .I_GRP(I_GRP), .I_GWP(I_GWP), .I_GVP(I_GVP),
`endif
    .I_CRD(I_CRD), .I_CWR(I_CWR), .I_CA(I_CA), .I_CD(I_CD), .O_CD(O_CD),
    .O_CWAIT_N(O_CWAIT_N),
    .I_IPL_CS(I_IPL_CS), .I_RAM_CS(I_RAM_CS), .I_GB_CS(I_GB_CS),
    .I_GR_CS(I_GR_CS), .I_GG_CS(I_GG_CS),
    .I_VREQ(I_VREQ), .I_GA(I_GA),
    .O_GB_D(O_GB_D), .O_GR_D(O_GR_D), .O_GG_D(O_GG_D),
    .O_VACK(O_VACK), .O_VOVR(O_VOVR),
    .O_SRAM_A(O_SRAM_A), .O_SRAM_D(O_SRAM_D), .I_SRAM_D(I_SRAM_D),
    .O_SRAM_OE(O_SRAM_OE), .O_SRAM_WE(O_SRAM_WE), .O_SRAM_WC(O_SRAM_WC)
  );

  // SRAM model and activity log, sampled mid-low-phase after stimulus settles.
  always @(negedge I_CLK) begin
    #3;
    cyc++;
    if (O_SRAM_WE === 1'b1) mem[O_SRAM_A] = O_SRAM_D;
    if ((O_SRAM_OE === 1'b1) || (O_SRAM_WC === 1'b1)) begin
      if (log_n < 64) begin
        addr_log[log_n] = O_SRAM_A;
        we_log[log_n]   = O_SRAM_WE;
        wc_log[log_n]   = O_SRAM_WC;
      end
      log_n++;
    end
    if (O_VACK === 1'b1) begin vack_n++; vack_cyc = cyc; end
    if (O_VOVR === 1'b1) vovr_n++;
    if (I_VREQ === 1'b1) vreq_cyc = cyc;
  end

  task automatic wait_cwait(output int n);
    n = 0;
    while (O_CWAIT_N !== 1'b1 && n < 40) begin
      n++;
      @(negedge I_CLK); #1;
    end
  endtask

  task automatic release_cpu();
    I_CRD = 0; I_CWR = 0;
    I_IPL_CS = 0; I_RAM_CS = 0; I_GB_CS = 0; I_GR_CS = 0; I_GG_CS = 0;
  endtask

  task automatic test_reset();
    int n;
    I_RESET = 1; I_CRD = 1; I_RAM_CS = 1; I_CA = 16'h1234;
    @(negedge I_CLK); #1;
    total++; if (O_CWAIT_N !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b want=1", O_CWAIT_N); end
    total++; if (O_CD !== 8'hFF) begin bad++; $display("FAIL rst_cd got=%h want=ff", O_CD); end
    total++; if ({O_SRAM_OE, O_SRAM_WE, O_SRAM_WC} !== 3'b000) begin bad++; $display("FAIL rst_sram got=%b want=000", {O_SRAM_OE, O_SRAM_WE, O_SRAM_WC}); end
    @(negedge I_CLK); #1;
    total++; if ({O_VACK, O_VOVR, O_GB_D, O_GR_D, O_GG_D, O_SRAM_OE, O_CWAIT_N} !== 28'h0000001) begin bad++; $display("FAIL rst_hold got=%h want=0000001", {O_VACK, O_VOVR, O_GB_D, O_GR_D, O_GG_D, O_SRAM_OE, O_CWAIT_N}); end
    I_RESET = 0; #1;
    total++; if ({O_SRAM_OE, O_CWAIT_N, O_SRAM_A} !== {2'b10, 18'h01234}) begin bad++; $display("FAIL rst_rel_rd got=%b/%b/%h want=1/0/01234", O_SRAM_OE, O_CWAIT_N, O_SRAM_A); end
    wait_cwait(n);
    total++; if (n !== 3) begin bad++; $display("FAIL rst_rd_wait got=%0d want=3", n); end
    total++; if (O_CD !== 8'h5A) begin bad++; $display("FAIL rst_rd_cd got=%h want=5a", O_CD); end
    release_cpu();
  endtask

  task automatic test_write_read();
    int n;
    log_n = 0;
    @(negedge I_CLK);
    I_CA = 16'h1234; I_CD = 8'hA5; I_RAM_CS = 1; I_CWR = 1; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 3) begin bad++; $display("FAIL wr_wait got=%0d want=3", n); end
    @(negedge I_CLK); #4;
    total++; if (log_n !== 3) begin bad++; $display("FAIL wr_slot_len got=%0d want=3", log_n); end
    total++; if ({addr_log[0], addr_log[1], addr_log[2]} !== {3{18'h01234}}) begin bad++; $display("FAIL wr_addr got=%h,%h,%h want=01234", addr_log[0], addr_log[1], addr_log[2]); end
    total++; if ({we_log[0], we_log[1], we_log[2], wc_log[0], wc_log[1], wc_log[2]} !== 6'b010111) begin bad++; $display("FAIL wr_we_wc got=%b want=010111", {we_log[0], we_log[1], we_log[2], wc_log[0], wc_log[1], wc_log[2]}); end
    total++; if (mem[18'h01234] !== 8'hA5) begin bad++; $display("FAIL wr_mem got=%h want=a5", mem[18'h01234]); end
    total++; if (O_CD !== 8'h5A) begin bad++; $display("FAIL wr_cd_hold got=%h want=5a", O_CD); end
    log_n = 0;
    @(negedge I_CLK);
    I_CRD = 1; I_RAM_CS = 1; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 3) begin bad++; $display("FAIL rd_wait got=%0d want=3", n); end
    total++; if (O_CD !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h want=a5", O_CD); end
    total++; if ({wc_log[0], wc_log[1], wc_log[2]} !== 3'b000) begin bad++; $display("FAIL rd_nowc got=%b want=000", {wc_log[0], wc_log[1], wc_log[2]}); end
  endtask

  // Video request one cycle ahead of the CPU read so both are pending at one decision.
  task automatic test_arbitration();
    int n;
    log_n = 0;
    @(negedge I_CLK); I_VREQ = 1; I_GA = 14'h0020;
    @(negedge I_CLK); I_VREQ = 0; I_CRD = 1; I_RAM_CS = 1; I_CA = 16'h0042; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 12) begin bad++; $display("FAIL arb1_wait got=%0d want=12", n); end
    total++; if ({addr_log[0], addr_log[9]} !== {18'h20020, 18'h00042}) begin bad++; $display("FAIL arb1_order got=%h,%h want=20020,00042", addr_log[0], addr_log[9]); end
    total++; if (O_CD !== 8'h77) begin bad++; $display("FAIL arb1_cd got=%h want=77", O_CD); end
    @(negedge I_CLK); I_VREQ = 1; I_GA = 14'h0100;
    @(negedge I_CLK); I_VREQ = 0;
    repeat (12) @(negedge I_CLK);
    log_n = 0;
    @(negedge I_CLK); I_VREQ = 1; I_GA = 14'h0030;
    @(negedge I_CLK); I_VREQ = 0; I_CRD = 1; I_RAM_CS = 1; I_CA = 16'h0043; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 3) begin bad++; $display("FAIL arb2_wait got=%0d want=3", n); end
    total++; if (O_CD !== 8'h88) begin bad++; $display("FAIL arb2_cd got=%h want=88", O_CD); end
    repeat (12) @(negedge I_CLK);
    total++; if ({addr_log[0], addr_log[3], addr_log[9]} !== {18'h00043, 18'h20030, 18'h28030} || log_n !== 12) begin bad++; $display("FAIL arb2_order got=%h,%h,%h n=%0d want=00043,20030,28030 n=12", addr_log[0], addr_log[3], addr_log[9], log_n); end
  endtask

  task automatic test_video();
    log_n = 0; vack_n = 0;
    @(negedge I_CLK); I_VREQ = 1; I_GA = 14'h0010;
    @(negedge I_CLK); I_VREQ = 0;
    for (int i = 0; i < 30; i++) begin
      if (vack_n != 0) break;
      @(negedge I_CLK);
    end
    repeat (3) @(negedge I_CLK);
    total++; if (vack_n !== 1) begin bad++; $display("FAIL vid_ack_cnt got=%0d want=1", vack_n); end
    total++; if (vack_cyc - vreq_cyc !== 10) begin bad++; $display("FAIL vid_latency got=%0d want=10", vack_cyc - vreq_cyc); end
    total++; if ({addr_log[0], addr_log[3], addr_log[6]} !== {18'h20010, 18'h24010, 18'h28010}) begin bad++; $display("FAIL vid_addr got=%h,%h,%h want=20010,24010,28010", addr_log[0], addr_log[3], addr_log[6]); end
    total++; if ({O_GB_D, O_GR_D, O_GG_D} !== 24'h112233) begin bad++; $display("FAIL vid_data got=%h want=112233", {O_GB_D, O_GR_D, O_GG_D}); end
  endtask

  task automatic test_overflow();
    vovr_n = 0; vack_n = 0;
    @(negedge I_CLK); I_VREQ = 1; I_GA = 14'h0040;
    @(negedge I_CLK); I_VREQ = 0;
    @(negedge I_CLK); I_VREQ = 1; I_GA = 14'h0050;
    @(negedge I_CLK); I_VREQ = 0;
    repeat (15) @(negedge I_CLK);
    total++; if (vovr_n !== 1) begin bad++; $display("FAIL ovr_pulse got=%0d want=1", vovr_n); end
    total++; if (vack_n !== 1) begin bad++; $display("FAIL ovr_ack got=%0d want=1", vack_n); end
  endtask

  task automatic test_nocs();
    int n;
    log_n = 0;
    @(negedge I_CLK); I_CRD = 1; I_CA = 16'h1234; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 1) begin bad++; $display("FAIL nocs_wait got=%0d want=1", n); end
    total++; if (O_CD !== 8'hFF) begin bad++; $display("FAIL nocs_cd got=%h want=ff", O_CD); end
    @(negedge I_CLK); #4;
    total++; if (log_n !== 0) begin bad++; $display("FAIL nocs_idle got=%0d want=0", log_n); end
    log_n = 0;
    @(negedge I_CLK); I_CRD = 1; I_IPL_CS = 1; I_RAM_CS = 1; I_CA = 16'h8123; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 3 || O_CD !== 8'h3C || addr_log[0] !== 18'h10123) begin bad++; $display("FAIL ipl_prio got=%0d/%h/%h want=3/3c/10123", n, O_CD, addr_log[0]); end
    log_n = 0;
    @(negedge I_CLK); I_CRD = 1; I_CWR = 1; I_RAM_CS = 1; I_CA = 16'h1234; I_CD = 8'h00; #1;
    wait_cwait(n);
    release_cpu();
    total++; if (n !== 3 || O_CD !== 8'hA5) begin bad++; $display("FAIL rdwr_read got=%0d/%h want=3/a5", n, O_CD); end
    total++; if ({wc_log[0], wc_log[1], wc_log[2]} !== 3'b000 || mem[18'h01234] !== 8'hA5) begin bad++; $display("FAIL rdwr_nowrite got=%b/%h want=000/a5", {wc_log[0], wc_log[1], wc_log[2]}, mem[18'h01234]); end
  endtask

  task automatic test_gbank();
    int n;
    logic [17:0] exp_a;
`ifdef SRAM_ARB_GBANK_EN
    exp_a = 18'h34000;
    I_GRP = 0; I_GWP = 1;
`else
    exp_a = 18'h24000;
`endif
    log_n = 0;
    @(negedge I_CLK); I_CWR = 1; I_GR_CS = 1; I_CA = 16'h0000; I_CD = 8'h5E; #1;
    wait_cwait(n);
    release_cpu();
    @(negedge I_CLK); #4;
    total++; if (n !== 3 || addr_log[0] !== exp_a) begin bad++; $display("FAIL gbank_addr got=%0d/%h want=3/%h", n, addr_log[0], exp_a); end
    total++; if (mem[exp_a] !== 8'h5E) begin bad++; $display("FAIL gbank_mem got=%h want=5e", mem[exp_a]); end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    mem[18'h01234] = 8'h5A;
    mem[18'h00042] = 8'h77;
    mem[18'h00043] = 8'h88;
    mem[18'h10123] = 8'h3C;
    mem[18'h20010] = 8'h11;
    mem[18'h24010] = 8'h22;
    mem[18'h28010] = 8'h33;
    I_CRD = 0; I_CWR = 0; I_VREQ = 0; I_CA = 16'h0; I_CD = 8'h0; I_GA = 14'h0;
    I_IPL_CS = 0; I_RAM_CS = 0; I_GB_CS = 0; I_GR_CS = 0; I_GG_CS = 0;
`ifdef SRAM_ARB_GBANK_EN
    I_GRP = 0; I_GWP = 0; I_GVP = 0;
`endif
    test_reset();
    test_write_read();
    test_arbitration();
    test_video();
    test_overflow();
    test_nocs();
    test_gbank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
